rob: RTL and testbench

ROB -- requirements
Module: rob

---
 rtl/rob_pkg.sv | 20 ++
 rtl/rob_retire_sel.sv | 25 ++
 rtl/rob.sv | 151 +++++++++++++++
 tb/tb_rob.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer.
//   PHYS_TAG  : physical register tag
//   ROB_IDX   : entry index for a default-sized (32-entry) buffer
//   ROB_ENTRY : per-entry state (valid, done, has_dest, told)
package rob_pkg;

  localparam int unsigned PHYS_TAG_W     = 6;
  localparam int unsigned ROB_SZ_DEFAULT = 32;

  typedef logic [PHYS_TAG_W-1:0]              PHYS_TAG;
  typedef logic [$clog2(ROB_SZ_DEFAULT)-1:0]  ROB_IDX;

  typedef struct packed {
    logic    valid;
    logic    done;
    logic    has_dest;
    PHYS_TAG told;
  } ROB_ENTRY;

endpackage

// File: rtl/rob_retire_sel.sv
// Retire mask selection for the reorder buffer.
// Lane i of the head window retires only when it and every earlier lane are valid and done.
//   valid  : valid bits of entries head+0 .. head+N-1
//   done   : done bits of the same entries
//   retire : contiguous-prefix retire mask
module rob_retire_sel #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] valid,
  input  logic [N-1:0] done,
  output logic [N-1:0] retire
);

  logic run;

  always_comb begin
    retire = '0;
    run    = 1'b1;
    for (int i = 0; i < N; i++) begin
      run       = run & valid[i] & done[i];
      retire[i] = run;
    end
  end

endmodule

// File: rtl/rob.sv
// Reorder buffer: circular buffer with head/tail pointers plus wrap bits.
// Dispatches, completes and retires up to N entries per cycle.
//   clock/reset_n   : rising-edge clock, asynchronous active-low reset
//   DispatchEN      : per-lane dispatch request (contiguous prefix from lane 0)
//   DispatchHasDest : lane writes a destination register
//   DispatchTold    : previous mapping of the destination
//   DispatchIdx     : entry index allocated to each lane (tail+i)
//   SpaceAvail      : min(free entries, N), from registered state only
//   CompleteEN/Idx  : per-lane completion strobes
//   RetireEN/Reg    : Told returned to the freelist
//   Empty           : no valid entries
// Optional: define ROB_PERF_CNT_EN to add a saturating 32-bit RetireCount output.
`ifndef N
`define N 2
`endif

module rob
  import rob_pkg::*;
#(
  parameter int unsigned N            = `N,
  parameter int unsigned ROB_SZ       = 32,
  parameter bit          EXCLUDE_ZERO = 1'b1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [N-1:0]                     DispatchEN,
  input  logic [N-1:0]                     DispatchHasDest,
  input  PHYS_TAG [N-1:0]                  DispatchTold,
  output logic [N-1:0][$clog2(ROB_SZ)-1:0] DispatchIdx,
  output logic [$clog2(N+1)-1:0]           SpaceAvail,
  input  logic [N-1:0]                     CompleteEN,
  input  logic [N-1:0][$clog2(ROB_SZ)-1:0] CompleteIdx,
  output logic [N-1:0]                     RetireEN,
  output PHYS_TAG [N-1:0]                  RetireReg,
  output logic                             Empty
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]                      RetireCount
`endif
);

  localparam int unsigned IDX_W = $clog2(ROB_SZ);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(N + 1);

  logic [IDX_W-1:0] head_q, tail_q;
  logic             head_wrap_q, tail_wrap_q;
  ROB_ENTRY         entries_q [ROB_SZ];

  logic [PTR_W-1:0] occupancy, free_cnt;
  logic [PTR_W-1:0] n_disp, n_ret;
  logic [N-1:0]     disp_ok;
  logic [N-1:0][IDX_W-1:0] win_idx;
  ROB_ENTRY [N-1:0] win_entry;
  logic [N-1:0]     win_valid, win_done, ret_mask;

  // Wrap bits extend the pointers so full and empty are distinguishable.
  assign occupancy = {tail_wrap_q, tail_q} - {head_wrap_q, head_q};
  assign free_cnt  = PTR_W'(ROB_SZ) - occupancy;
  assign Empty     = (occupancy == '0);

  always_comb begin
    if (free_cnt >= PTR_W'(N)) SpaceAvail = CNT_W'(N);
    else                       SpaceAvail = CNT_W'(free_cnt);
  end

  always_comb begin
    n_disp = '0;
    for (int i = 0; i < N; i++) begin
      DispatchIdx[i] = tail_q + IDX_W'(i);
      // Lanes at or beyond the free space are dropped entirely.
      disp_ok[i]     = DispatchEN[i] && (CNT_W'(i) < SpaceAvail);
      n_disp         = n_disp + PTR_W'(disp_ok[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      win_idx[i]   = head_q + IDX_W'(i);
      win_entry[i] = entries_q[win_idx[i]];
      win_valid[i] = win_entry[i].valid;
      win_done[i]  = win_entry[i].done;
    end
  end

  rob_retire_sel #(
    .N(N)
  ) u_retire_sel (
    .valid  (win_valid),
    .done   (win_done),
    .retire (ret_mask)
  );

  always_comb begin
    n_ret = '0;
    for (int i = 0; i < N; i++) begin
      n_ret        = n_ret + PTR_W'(ret_mask[i]);
      RetireEN[i]  = ret_mask[i] && win_entry[i].has_dest &&
                     (!EXCLUDE_ZERO || (win_entry[i].told != '0));
      RetireReg[i] = RetireEN[i] ? win_entry[i].told : '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      head_wrap_q <= 1'b0;
      tail_wrap_q <= 1'b0;
      for (int i = 0; i < ROB_SZ; i++) entries_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (CompleteEN[i] && entries_q[CompleteIdx[i]].valid) begin
          entries_q[CompleteIdx[i]].done <= 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (ret_mask[i]) begin
          entries_q[win_idx[i]].valid <= 1'b0;
          entries_q[win_idx[i]].done  <= 1'b0;
        end
      end
      // Dispatch targets only free entries, so it never collides with retirement.
      for (int i = 0; i < N; i++) begin
        if (disp_ok[i]) begin
          entries_q[DispatchIdx[i]] <= '{valid: 1'b1, done: 1'b0,
                                         has_dest: DispatchHasDest[i],
                                         told: DispatchTold[i]};
        end
      end
      {head_wrap_q, head_q} <= {head_wrap_q, head_q} + n_ret;
      {tail_wrap_q, tail_q} <= {tail_wrap_q, tail_q} + n_disp;
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] retire_count_q;
  logic [32:0] count_sum;

  assign count_sum = {1'b0, retire_count_q} + 33'(n_ret);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)          retire_count_q <= '0;
    else if (count_sum[32]) retire_count_q <= '1;
    else                   retire_count_q <= count_sum[31:0];
  end

  assign RetireCount = retire_count_q;
`endif

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for the reorder buffer (N=2, ROB_SZ=8, EXCLUDE_ZERO=1).
module tb_rob;
  import rob_pkg::*;

  localparam int unsigned N      = 2;
  localparam int unsigned ROB_SZ = 8;
  localparam int unsigned IW     = 3;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [N-1:0]          DispatchEN, DispatchHasDest, CompleteEN, RetireEN;
  PHYS_TAG [N-1:0]       DispatchTold, RetireReg;
  logic [N-1:0][IW-1:0]  DispatchIdx, CompleteIdx;
  logic [1:0]            SpaceAvail;
  logic                  Empty;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]           RetireCount;
`endif

  rob #(
    .N            (N),
    .ROB_SZ       (ROB_SZ),
    .EXCLUDE_ZERO (1'b1)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .DispatchEN      (DispatchEN),
    .DispatchHasDest (DispatchHasDest),
    .DispatchTold    (DispatchTold),
    .DispatchIdx     (DispatchIdx),
    .SpaceAvail      (SpaceAvail),
    .CompleteEN      (CompleteEN),
    .CompleteIdx     (CompleteIdx),
    .RetireEN        (RetireEN),
    .RetireReg       (RetireReg),
    .Empty           (Empty)
`ifdef ROB_PERF_CNT_EN
    ,
    .RetireCount     (RetireCount)
`endif
  );

  always #5 clock = ~clock;

  int      checks = 0;
  int      errors = 0;
  PHYS_TAG exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor: every returned tag must be the next expected one, in order.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      for (int l = 0; l < N; l++) begin
        if (RetireEN[l]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL retire_unexpected lane %0d: got tag %0d, required no return",
                     l, RetireReg[l]);
          end else begin
            PHYS_TAG e;
            e = exp_q.pop_front();
            check($sformatf("retire_tag_lane%0d", l), 32'(RetireReg[l]), 32'(e));
          end
        end else begin
          check($sformatf("retire_reg_idle_lane%0d", l), 32'(RetireReg[l]), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    DispatchEN      = '0;
    DispatchHasDest = '0;
    DispatchTold    = '0;
    CompleteEN      = '0;
    CompleteIdx     = '0;
  endtask

  task automatic dispatch2(input PHYS_TAG t0, input PHYS_TAG t1, input logic hd0,
                           input logic hd1, input bit accepted);
    DispatchEN      = 2'b11;
    DispatchHasDest = {hd1, hd0};
    DispatchTold    = {t1, t0};
    if (accepted) begin
      if (hd0 && t0 != '0) exp_q.push_back(t0);
      if (hd1 && t1 != '0) exp_q.push_back(t1);
    end
  endtask

  task automatic complete2(input logic [1:0] en, input logic [IW-1:0] i0,
                           input logic [IW-1:0] i1);
    CompleteEN  = en;
    CompleteIdx = {i1, i0};
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 20; c++) begin
      if (Empty) break;
      tick();
    end
    check(name, 32'(Empty), 32'd1);
  endtask

  logic [IW-1:0] tail_m, prev;
  bit            have_prev;

  task automatic stream(input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      dispatch2(PHYS_TAG'(20 + 2 * k), PHYS_TAG'(21 + 2 * k), 1'b1, 1'b1, 1'b1);
      if (have_prev) complete2(2'b11, prev, prev + 3'd1);
      check("stream_idx0", 32'(DispatchIdx[0]), 32'(tail_m));
      check("stream_idx1", 32'(DispatchIdx[1]), 32'(tail_m + 3'd1));
      tick();
      prev      = tail_m;
      have_prev = 1'b1;
      tail_m    = tail_m + 3'd2;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n         = 1'b0;
    DispatchEN      = '0;
    DispatchHasDest = '0;
    DispatchTold    = '0;
    CompleteEN      = '0;
    CompleteIdx     = '0;
    #2;
    check("rst_empty", 32'(Empty), 32'd1);
    check("rst_space", 32'(SpaceAvail), 32'd2);
    check("rst_retire_en", 32'(RetireEN), 32'd0);
    check("rst_idx", 32'(DispatchIdx), 32'({3'd1, 3'd0}));
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Two dispatches, both complete, both retire together.
    dispatch2(6'd5, 6'd6, 1'b1, 1'b1, 1'b1);
    check("t1_idx", 32'(DispatchIdx), 32'({3'd1, 3'd0}));
    tick();
    check("t1_not_empty", 32'(Empty), 32'd0);
    complete2(2'b11, 3'd0, 3'd1);
    tick();
    check("t1_retire_en", 32'(RetireEN), 32'd3);
    check("t1_retire_reg", 32'(RetireReg), 32'({6'd6, 6'd5}));
    tick();
    check("t1_empty", 32'(Empty), 32'd1);

    // Younger entry completes first: nothing retires until the older one does.
    dispatch2(6'd7, 6'd8, 1'b1, 1'b1, 1'b1);
    check("t2_idx0", 32'(DispatchIdx[0]), 32'd2);
    tick();
    complete2(2'b01, 3'd3, 3'd0);
    tick();
    check("t2_hold_a", 32'(RetireEN), 32'd0);
    tick();
    check("t2_hold_b", 32'(RetireEN), 32'd0);
    complete2(2'b10, 3'd0, 3'd2);
    tick();
    check("t2_retire_en", 32'(RetireEN), 32'd3);
    check("t2_retire_reg", 32'(RetireReg), 32'({6'd8, 6'd7}));
    tick();
    check("t2_empty", 32'(Empty), 32'd1);

    // Told=0 with a destination, and no destination: retire silently.
    dispatch2(6'd0, 6'd9, 1'b1, 1'b0, 1'b1);
    check("t3_idx0", 32'(DispatchIdx[0]), 32'd4);
    tick();
    complete2(2'b11, 3'd4, 3'd5);
    tick();
    check("t3_retire_en", 32'(RetireEN), 32'd0);
    check("t3_still_valid", 32'(Empty), 32'd0);
    tick();
    check("t3_empty", 32'(Empty), 32'd1);

    // Fill all 8 entries starting at index 6, then try to overflow.
    for (int c = 0; c < 4; c++) begin
      check("t4_space", 32'(SpaceAvail), 32'd2);
      dispatch2(PHYS_TAG'(10 + 2 * c), PHYS_TAG'(11 + 2 * c), 1'b1, 1'b1, 1'b1);
      check("t4_idx0", 32'(DispatchIdx[0]), 32'((6 + 2 * c) % 8));
      tick();
    end
    check("t4_full_space", 32'(SpaceAvail), 32'd0);
    dispatch2(6'd30, 6'd31, 1'b1, 1'b1, 1'b0);
    check("t4_full_idx_a", 32'(DispatchIdx[0]), 32'd6);
    tick();
    check("t4_full_idx_b", 32'(DispatchIdx[0]), 32'd6);
    check("t4_full_space_b", 32'(SpaceAvail), 32'd0);
    complete2(2'b11, 3'd6, 3'd7);
    tick();
    check("t4_space_not_early", 32'(SpaceAvail), 32'd0);
    complete2(2'b11, 3'd0, 3'd1);
    tick();
    check("t4_space_freed", 32'(SpaceAvail), 32'd2);
    complete2(2'b11, 3'd2, 3'd3);
    tick();
    complete2(2'b11, 3'd4, 3'd5);
    tick();
    drain("t4_drain_empty");

    // Streaming across the 7->0 wrap, with a reset in the middle.
    tail_m    = 3'd6;
    have_prev = 1'b0;
    stream(0, 12);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_rst_empty", 32'(Empty), 32'd1);
    check("t5_rst_space", 32'(SpaceAvail), 32'd2);
    check("t5_rst_retire_en", 32'(RetireEN), 32'd0);
    check("t5_rst_retire_reg", 32'(RetireReg), 32'd0);
    check("t5_rst_idx", 32'(DispatchIdx), 32'({3'd1, 3'd0}));
    tick();
    reset_n   = 1'b1;
    tail_m    = 3'd0;
    have_prev = 1'b0;
    stream(12, 8);
    complete2(2'b11, prev, prev + 3'd1);
    tick();
    drain("t5_drain_empty");
    tick();
    check("t5_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
